// File: rtl/pin_deck_sequencer.sv
// pin_deck_sequencer
// Turns raw pin-deck sensors and a ball-passed pulse into one roll pulse per
// ball, carrying the number of pins newly knocked down. Tracks frame and ball
// position (including the 10th-frame bonus balls), requests rack resets and,
// at game end, holds calculate_score for the downstream scorer.

module pin_deck_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int RACK_CYCLES   = 32,
    parameter int SCORE_CYCLES  = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] pins_up,
    input  logic       ball_done,
    input  logic       new_game,
    output logic       roll,
    output logic [3:0] pin_count,
    output logic       calculate_score,
    output logic       rack_reset,
    output logic       game_start,
    output logic [3:0] frame,
    output logic [1:0] ball_in_frame,
    output logic       game_over,
    output logic       ball_ignored
);

    // State encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_RACK   = 3'd3;
    localparam logic [2:0] ST_SCORE  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // One shared down-counter serves SETTLE, RACK and SCORE. SCORE loads one
    // extra count so that calculate_score rises only after the roll cycle.
    localparam int MAX_A = (SETTLE_CYCLES > RACK_CYCLES) ? SETTLE_CYCLES : RACK_CYCLES;
    localparam int MAX_B = (MAX_A > (SCORE_CYCLES + 1)) ? MAX_A : (SCORE_CYCLES + 1);
    localparam int CNT_W = $clog2(MAX_B + 1);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] RACK_LOAD   = CNT_W'(RACK_CYCLES);
    localparam logic [CNT_W-1:0] SCORE_LOAD  = CNT_W'(SCORE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [3:0] FIRST_FRAME = 4'd1;
    localparam logic [3:0] LAST_FRAME  = 4'd10;
    localparam logic [3:0] FULL_RACK   = 4'd10;
    localparam logic [9:0] ALL_PINS    = 10'h3FF;

    // Number of set bits in a 10-pin mask (result 0..10)
    function automatic logic [3:0] pop10(input logic [9:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 10; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    logic [2:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [9:0]       standing_r;
    logic [9:0]       knocked_r;
    logic [3:0]       ball1_count_r;
    logic [3:0]       frame_r;
    logic [1:0]       ball_r;

    logic             roll_r;
    logic [3:0]       pin_count_r;
    logic             calc_r;
    logic             rack_reset_r;
    logic             game_start_r;
    logic             game_over_r;
    logic             ball_ignored_r;

    logic [3:0]       count_s;
    logic             strike_s;
    logic [4:0]       frame_sum_s;
    logic             adv_rack_s;
    logic             adv_end_s;
    logic [3:0]       nxt_frame_s;
    logic [1:0]       nxt_ball_s;

    // Pins knocked by the ball being reported, and frame-10 spare sum
    always_comb begin
        count_s     = pop10(knocked_r);
        strike_s    = (count_s == FULL_RACK);
        frame_sum_s = {1'b0, ball1_count_r} + {1'b0, count_s};
    end

    // Frame/ball advance decision applied when the roll is reported
    always_comb begin
        adv_rack_s  = 1'b0;
        adv_end_s   = 1'b0;
        nxt_frame_s = frame_r;
        nxt_ball_s  = ball_r;
        if (frame_r != LAST_FRAME) begin
            if (ball_r == 2'd1) begin
                if (strike_s) begin
                    adv_rack_s  = 1'b1;
                    nxt_frame_s = frame_r + 4'd1;
                    nxt_ball_s  = 2'd1;
                end else begin
                    nxt_ball_s  = 2'd2;
                end
            end else begin
                adv_rack_s  = 1'b1;
                nxt_frame_s = frame_r + 4'd1;
                nxt_ball_s  = 2'd1;
            end
        end else begin
            case (ball_r)
                2'd1: begin
                    adv_rack_s = strike_s;
                    nxt_ball_s = 2'd2;
                end
                2'd2: begin
                    if (ball1_count_r == FULL_RACK) begin
                        adv_rack_s = strike_s;
                        nxt_ball_s = 2'd3;
                    end else if (frame_sum_s == 5'd10) begin
                        adv_rack_s = 1'b1;
                        nxt_ball_s = 2'd3;
                    end else begin
                        adv_end_s  = 1'b1;
                    end
                end
                default: begin
                    adv_end_s = 1'b1;
                end
            endcase
        end
    end

    // Sequencer state machine with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= '0;
            standing_r     <= ALL_PINS;
            knocked_r      <= 10'd0;
            ball1_count_r  <= 4'd0;
            frame_r        <= FIRST_FRAME;
            ball_r         <= 2'd1;
            roll_r         <= 1'b0;
            pin_count_r    <= 4'd0;
            calc_r         <= 1'b0;
            rack_reset_r   <= 1'b0;
            game_start_r   <= 1'b0;
            game_over_r    <= 1'b0;
            ball_ignored_r <= 1'b0;
        end else begin
            // pulse outputs default low each cycle
            roll_r         <= 1'b0;
            pin_count_r    <= 4'd0;
            rack_reset_r   <= 1'b0;
            game_start_r   <= 1'b0;
            ball_ignored_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ball_done) begin
                        state_r <= ST_SETTLE;
                        cnt_r   <= SETTLE_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    ball_ignored_r <= ball_done;
                    if (cnt_r == CNT_ONE) begin
                        // settled: latch knocked pins; reappearing pins stay down
                        knocked_r  <= standing_r & ~pins_up;
                        standing_r <= standing_r & pins_up;
                        state_r    <= ST_SAMPLE;
                    end else begin
                        cnt_r      <= cnt_r - CNT_ONE;
                    end
                end
                ST_SAMPLE: begin
                    ball_ignored_r <= ball_done;
                    roll_r         <= 1'b1;
                    pin_count_r    <= count_s;
                    if (ball_r == 2'd1) begin
                        ball1_count_r <= count_s;
                    end else begin
                        ball1_count_r <= ball1_count_r;
                    end
                    frame_r <= nxt_frame_s;
                    ball_r  <= nxt_ball_s;
                    if (adv_end_s) begin
                        state_r <= ST_SCORE;
                        cnt_r   <= SCORE_LOAD;
                    end else if (adv_rack_s) begin
                        state_r      <= ST_RACK;
                        cnt_r        <= RACK_LOAD;
                        rack_reset_r <= 1'b1;
                        standing_r   <= ALL_PINS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RACK: begin
                    ball_ignored_r <= ball_done;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                    end
                end
                ST_SCORE: begin
                    ball_ignored_r <= ball_done;
                    if (cnt_r == CNT_ONE) begin
                        state_r     <= ST_DONE;
                        calc_r      <= 1'b0;
                        game_over_r <= 1'b1;
                    end else begin
                        calc_r      <= 1'b1;
                        cnt_r       <= cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    // ball_done is dropped silently here; new_game wins
                    if (new_game) begin
                        game_start_r <= 1'b1;
                        rack_reset_r <= 1'b1;
                        standing_r   <= ALL_PINS;
                        frame_r      <= FIRST_FRAME;
                        ball_r       <= 2'd1;
                        game_over_r  <= 1'b0;
                        state_r      <= ST_RACK;
                        cnt_r        <= RACK_LOAD;
                    end else begin
                        state_r      <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign roll            = roll_r;
    assign pin_count       = pin_count_r;
    assign calculate_score = calc_r;
    assign rack_reset      = rack_reset_r;
    assign game_start      = game_start_r;
    assign frame           = frame_r;
    assign ball_in_frame   = ball_r;
    assign game_over       = game_over_r;
    assign ball_ignored    = ball_ignored_r;

endmodule

// File: tb/tb_pin_deck_sequencer.sv
// Directed testbench for pin_deck_sequencer.
module tb_pin_deck_sequencer;

    localparam int SETTLE = 16;
    localparam int RACK   = 32;
    localparam int SCORE  = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] pins_up;
    logic       ball_done;
    logic       new_game;
    logic       roll;
    logic [3:0] pin_count;
    logic       calculate_score;
    logic       rack_reset;
    logic       game_start;
    logic [3:0] frame;
    logic [1:0] ball_in_frame;
    logic       game_over;
    logic       ball_ignored;

    pin_deck_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .RACK_CYCLES  (RACK),
        .SCORE_CYCLES (SCORE)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pins_up        (pins_up),
        .ball_done      (ball_done),
        .new_game       (new_game),
        .roll           (roll),
        .pin_count      (pin_count),
        .calculate_score(calculate_score),
        .rack_reset     (rack_reset),
        .game_start     (game_start),
        .frame          (frame),
        .ball_in_frame  (ball_in_frame),
        .game_over      (game_over),
        .ball_ignored   (ball_ignored)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    int         lat_o;
    logic [3:0] cnt_o;
    logic       rack_o;
    logic [3:0] frame_o;
    logic [1:0] ball_o;
    int post_rolls, post_pc, post_racks, post_ign, post_gs, post_calc, post_calc_first;
    int roll_log [24];
    int roll_n;

    task step();
        @(posedge clock);
        #1;
    endtask

    task do_reset();
        reset = 1'b1; pins_up = 10'h3FF; ball_done = 1'b0; new_game = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        roll_n = 0;
        for (int i = 0; i < 24; i++) roll_log[i] = 0;
    endtask

    // waits (bounded) for the next roll and captures outputs on that cycle
    task wait_roll();
        lat_o = -1; cnt_o = 4'd0; rack_o = 1'b0; frame_o = 4'd0; ball_o = 2'd0;
        for (int n = 1; n <= 200; n++) begin
            step();
            if (roll === 1'b1) begin
                lat_o = n; cnt_o = pin_count; rack_o = rack_reset;
                frame_o = frame; ball_o = ball_in_frame;
                if (roll_n < 24) roll_log[roll_n] = int'(pin_count);
                roll_n++;
                break;
            end
        end
    endtask

    task fire_ball(input logic [9:0] p);
        pins_up = p; ball_done = 1'b1;
        step();
        ball_done = 1'b0;
        wait_roll();
    endtask

    // observes n cycles and tallies pulses / calculate_score
    task wait_post(input int n);
        post_rolls = 0; post_pc = 0; post_racks = 0; post_ign = 0; post_gs = 0;
        post_calc = 0; post_calc_first = -1;
        for (int i = 1; i <= n; i++) begin
            step();
            if (roll === 1'b1) post_rolls++;
            if (pin_count !== 4'd0) post_pc++;
            if (rack_reset === 1'b1) post_racks++;
            if (ball_ignored === 1'b1) post_ign++;
            if (game_start === 1'b1) post_gs++;
            if (calculate_score === 1'b1) begin
                post_calc++;
                if (post_calc_first < 0) post_calc_first = i;
            end
        end
    endtask

    // reference ten-pin scorer over the logged rolls
    function automatic int score_log();
        int s = 0;
        int i = 0;
        for (int f = 0; f < 10; f++) begin
            if (roll_log[i] == 10) begin
                s += 10 + roll_log[i+1] + roll_log[i+2]; i += 1;
            end else if (roll_log[i] + roll_log[i+1] == 10) begin
                s += 10 + roll_log[i+2]; i += 2;
            end else begin
                s += roll_log[i] + roll_log[i+1]; i += 2;
            end
        end
        return s;
    endfunction

    task test_reset();
        do_reset();
        n_checks++; if ({roll, pin_count, calculate_score, rack_reset, game_start, game_over, ball_ignored} !== 10'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0", {roll, pin_count, calculate_score, rack_reset, game_start, game_over, ball_ignored}); end
        n_checks++; if (frame !== 4'd1) begin n_fail++; $display("FAIL reset_frame: got %0d want 1", frame); end
        n_checks++; if (ball_in_frame !== 2'd1) begin n_fail++; $display("FAIL reset_ball: got %0d want 1", ball_in_frame); end
        new_game = 1'b1; step(); new_game = 1'b0;
        n_checks++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL new_game_idle: got %b want 0", game_start); end
        wait_post(100);
        n_checks++; if (post_rolls + post_racks + post_calc + post_ign + post_gs !== 0) begin
            n_fail++; $display("FAIL quiet_100: got %0d pulses want 0", post_rolls + post_racks + post_calc + post_ign + post_gs); end
    endtask

    task test_first_frame();
        int racks;
        do_reset();
        fire_ball(10'b0000000011);
        n_checks++; if (lat_o !== SETTLE + 1) begin n_fail++; $display("FAIL roll_latency: got %0d want %0d", lat_o, SETTLE + 1); end
        n_checks++; if (cnt_o !== 4'd8) begin n_fail++; $display("FAIL ball1_count: got %0d want 8", cnt_o); end
        n_checks++; if (ball_o !== 2'd2 || frame_o !== 4'd1 || rack_o !== 1'b0) begin
            n_fail++; $display("FAIL ball1_pos: got f%0d b%0d r%b want f1 b2 r0", frame_o, ball_o, rack_o); end
        wait_post(5);
        n_checks++; if (post_rolls + post_pc !== 0) begin n_fail++; $display("FAIL roll_width: got %0d extra want 0", post_rolls + post_pc); end
        fire_ball(10'b0000000001);
        n_checks++; if (cnt_o !== 4'd1) begin n_fail++; $display("FAIL ball2_count: got %0d want 1", cnt_o); end
        n_checks++; if (rack_o !== 1'b1 || frame_o !== 4'd2 || ball_o !== 2'd1) begin
            n_fail++; $display("FAIL ball2_pos: got f%0d b%0d r%b want f2 b1 r1", frame_o, ball_o, rack_o); end
        racks = 0;
        for (int i = 0; i < RACK - 1; i++) begin step(); if (rack_reset === 1'b1) racks++; end
        n_checks++; if (racks !== 0) begin n_fail++; $display("FAIL rack_width: got %0d extra want 0", racks); end
        ball_done = 1'b1; step();
        n_checks++; if (ball_ignored !== 1'b1) begin n_fail++; $display("FAIL rack_last_ignored: got %b want 1", ball_ignored); end
        step(); ball_done = 1'b0; pins_up = 10'h3FF;
        n_checks++; if (ball_ignored !== 1'b0) begin n_fail++; $display("FAIL rack_end_accept: got %b want 0", ball_ignored); end
        wait_roll();
        n_checks++; if (lat_o !== SETTLE + 1 || cnt_o !== 4'd0 || frame_o !== 4'd2 || ball_o !== 2'd2) begin
            n_fail++; $display("FAIL after_rack: got lat%0d c%0d f%0d b%0d want lat%0d c0 f2 b2", lat_o, cnt_o, frame_o, ball_o, SETTLE + 1); end
    endtask

    task test_perfect_game();
        int bad, racks, calc_pre;
        do_reset();
        bad = 0; racks = 0; calc_pre = 0;
        for (int b = 0; b < 12; b++) begin
            fire_ball(10'b0000000000);
            if (lat_o !== SETTLE + 1 || cnt_o !== 4'd10) bad++;
            racks += int'(rack_o);
            if (b < 11) begin wait_post(40); racks += post_racks; calc_pre += post_calc; end
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL perfect_rolls: got %0d bad rolls want 0", bad); end
        n_checks++; if (frame_o !== 4'd10 || rack_o !== 1'b0) begin n_fail++; $display("FAIL perfect_last: got f%0d r%b want f10 r0", frame_o, rack_o); end
        wait_post(20);
        racks += post_racks;
        n_checks++; if (racks !== 11) begin n_fail++; $display("FAIL perfect_racks: got %0d want 11", racks); end
        n_checks++; if (calc_pre !== 0 || post_calc !== SCORE || post_calc_first !== 1) begin
            n_fail++; $display("FAIL perfect_calc: got pre%0d n%0d first%0d want pre0 n%0d first1", calc_pre, post_calc, post_calc_first, SCORE); end
        n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL perfect_over: got %b want 1", game_over); end
        n_checks++; if (roll_n !== 12 || score_log() !== 300) begin
            n_fail++; $display("FAIL perfect_score: got rolls%0d score%0d want rolls12 score300", roll_n, score_log()); end
    endtask

    task test_tenth_open();
        int bad, racks, calc_pre;
        do_reset();
        bad = 0; racks = 0; calc_pre = 0;
        for (int b = 0; b < 20; b++) begin
            fire_ball(10'h3FF);
            if (lat_o !== SETTLE + 1 || cnt_o !== 4'd0) bad++;
            racks += int'(rack_o);
            if (b == 18) begin
                n_checks++; if (frame_o !== 4'd10 || ball_o !== 2'd2) begin
                    n_fail++; $display("FAIL open_f10b1: got f%0d b%0d want f10 b2", frame_o, ball_o); end
            end
            if (b < 19) begin wait_post(40); racks += post_racks; calc_pre += post_calc; end
        end
        n_checks++; if (bad !== 0 || racks !== 9) begin n_fail++; $display("FAIL open_rolls: got bad%0d racks%0d want bad0 racks9", bad, racks); end
        wait_post(20);
        n_checks++; if (calc_pre !== 0 || post_calc !== SCORE || game_over !== 1'b1 || post_racks !== 0) begin
            n_fail++; $display("FAIL open_end: got pre%0d n%0d over%b r%0d want pre0 n%0d over1 r0", calc_pre, post_calc, game_over, post_racks, SCORE); end
    endtask

    task test_tenth_spare();
        do_reset();
        for (int b = 0; b < 18; b++) begin fire_ball(10'h3FF); wait_post(40); end
        fire_ball(10'b1111100000);
        n_checks++; if (cnt_o !== 4'd5 || rack_o !== 1'b0 || ball_o !== 2'd2) begin
            n_fail++; $display("FAIL spare_b1: got c%0d r%b b%0d want c5 r0 b2", cnt_o, rack_o, ball_o); end
        wait_post(40);
        fire_ball(10'b0000000000);
        n_checks++; if (cnt_o !== 4'd5 || rack_o !== 1'b1 || ball_o !== 2'd3) begin
            n_fail++; $display("FAIL spare_b2: got c%0d r%b b%0d want c5 r1 b3", cnt_o, rack_o, ball_o); end
        wait_post(40);
        n_checks++; if (post_calc !== 0 || game_over !== 1'b0) begin n_fail++; $display("FAIL spare_early_end: got calc%0d over%b want 0 0", post_calc, game_over); end
        fire_ball(10'b1111111000);
        n_checks++; if (lat_o !== SETTLE + 1 || cnt_o !== 4'd3) begin n_fail++; $display("FAIL spare_b3: got lat%0d c%0d want lat%0d c3", lat_o, cnt_o, SETTLE + 1); end
        wait_post(20);
        n_checks++; if (post_calc !== SCORE || game_over !== 1'b1 || roll_n !== 21) begin
            n_fail++; $display("FAIL spare_end: got n%0d over%b rolls%0d want n%0d over1 rolls21", post_calc, game_over, roll_n, SCORE); end
    endtask

    task test_new_game();
        ball_done = 1'b1; step(); ball_done = 1'b0;
        n_checks++; if (ball_ignored !== 1'b0) begin n_fail++; $display("FAIL done_no_ignore: got %b want 0", ball_ignored); end
        wait_post(40);
        n_checks++; if (post_rolls !== 0 || post_ign !== 0 || game_over !== 1'b1) begin
            n_fail++; $display("FAIL done_ball: got rolls%0d ign%0d over%b want 0 0 1", post_rolls, post_ign, game_over); end
        new_game = 1'b1; ball_done = 1'b1; step(); new_game = 1'b0; ball_done = 1'b0;
        n_checks++; if (game_start !== 1'b1 || rack_reset !== 1'b1 || frame !== 4'd1 || ball_in_frame !== 2'd1 || game_over !== 1'b0) begin
            n_fail++; $display("FAIL new_game: got gs%b rr%b f%0d b%0d over%b want 1 1 1 1 0", game_start, rack_reset, frame, ball_in_frame, game_over); end
        wait_post(40);
        n_checks++; if (post_rolls !== 0 || post_gs !== 0 || post_racks !== 0) begin
            n_fail++; $display("FAIL new_game_after: got rolls%0d gs%0d rr%0d want 0 0 0", post_rolls, post_gs, post_racks); end
        fire_ball(10'b0000000011);
        n_checks++; if (lat_o !== SETTLE + 1 || cnt_o !== 4'd8 || ball_o !== 2'd2) begin
            n_fail++; $display("FAIL new_game_ball: got lat%0d c%0d b%0d want lat%0d c8 b2", lat_o, cnt_o, ball_o, SETTLE + 1); end
    endtask

    task test_settle_ignore();
        do_reset();
        pins_up = 10'b1111111110; ball_done = 1'b1; step(); ball_done = 1'b0;
        step(); ball_done = 1'b1; step(); ball_done = 1'b0;
        n_checks++; if (ball_ignored !== 1'b1) begin n_fail++; $display("FAIL settle_ignored: got %b want 1", ball_ignored); end
        wait_roll();
        n_checks++; if (lat_o !== SETTLE - 1 || cnt_o !== 4'd1) begin
            n_fail++; $display("FAIL settle_roll: got lat%0d c%0d want lat%0d c1", lat_o, cnt_o, SETTLE - 1); end
        wait_post(40);
        n_checks++; if (post_rolls !== 0 || post_ign !== 0) begin n_fail++; $display("FAIL settle_single: got rolls%0d ign%0d want 0 0", post_rolls, post_ign); end
        fire_ball(10'b0111111111);
        n_checks++; if (cnt_o !== 4'd1 || rack_o !== 1'b1 || frame_o !== 4'd2) begin
            n_fail++; $display("FAIL reappear: got c%0d r%b f%0d want c1 r1 f2", cnt_o, rack_o, frame_o); end
    endtask

    task test_reset_mid_settle();
        do_reset();
        fire_ball(10'b0000000011);
        wait_post(5);
        pins_up = 10'b0000000000; ball_done = 1'b1; step(); ball_done = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #1 reset = 1'b1;
        #2;
        n_checks++; if (ball_in_frame !== 2'd1 || frame !== 4'd1) begin
            n_fail++; $display("FAIL async_reset: got f%0d b%0d want f1 b1", frame, ball_in_frame); end
        step(); step(); reset = 1'b0;
        wait_post(40);
        n_checks++; if (post_rolls !== 0) begin n_fail++; $display("FAIL reset_no_roll: got %0d want 0", post_rolls); end
        fire_ball(10'b0000000011);
        n_checks++; if (cnt_o !== 4'd8 || ball_o !== 2'd2 || frame_o !== 4'd1) begin
            n_fail++; $display("FAIL reset_standing: got c%0d b%0d f%0d want c8 b2 f1", cnt_o, ball_o, frame_o); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_perfect_game();
        test_tenth_open();
        test_tenth_spare();
        test_new_game();
        test_settle_ignore();
        test_reset_mid_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pin_deck_sequencer.md
Name: pin_deck_sequencer

Overview:
- Upstream feeder for the bowling scorer; drives its roll / pin_count / calculate_score inputs.
- Turns raw pin-deck sensors plus a ball-passed pulse into one roll pulse per ball, carrying the count of pins newly knocked down.
- Tracks frame and ball position, including 10th-frame bonus balls, and requests rack resets.
- At game end, holds calculate_score for the scorer's evaluation window.

Parameters:
SETTLE_CYCLES, 16, cycles to wait after ball_done before sampling pins_up (pin wobble settle)
RACK_CYCLES, 32, cycles the deck is busy after a rack_reset request
SCORE_CYCLES, 10, cycles calculate_score is held high at game end

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
pins_up  input  10  raw pin sensors, 1 = pin standing
ball_done  input  1  one-cycle pulse, ball has passed the pins
new_game  input  1  one-cycle pulse, start a new game (honoured only in DONE)
roll  output  1  one-cycle pulse, pin_count valid
pin_count  output  4  pins knocked by this ball, 0..10; 0 when roll low
calculate_score  output  1  high for SCORE_CYCLES cycles at game end
rack_reset  output  1  one-cycle pulse, request full rack of 10 pins
game_start  output  1  one-cycle pulse on new_game acceptance (drives scorer reset)
frame  output  4  current frame, 1..10
ball_in_frame  output  2  current ball in frame, 1..3
game_over  output  1  high in DONE
ball_ignored  output  1  one-cycle pulse, ball_done arrived outside IDLE

Behaviour:
- Reset values: all pulse outputs 0, pin_count 0, calculate_score 0, game_over 0, frame 1, ball_in_frame 1, internal standing mask 10'h3FF, state IDLE. Reset takes effect immediately, including mid-SETTLE, RACK or SCORE; no roll is emitted for an interrupted ball.
- States: IDLE, SETTLE, SAMPLE, RACK, SCORE, DONE. All outputs are registered.
- IDLE: ball_done high at edge k -> SETTLE, counter loads SETTLE_CYCLES.
- SETTLE -> SAMPLE when the counter expires. pins_up is sampled at edge k+SETTLE_CYCLES.
- SAMPLE: knocked = standing & ~pins_up; pin_count = popcount(knocked), 4 bits, max 10; standing <= standing & pins_up.
- roll and pin_count are high for exactly one cycle, starting at edge k+SETTLE_CYCLES+1. pin_count returns to 0 with roll.
- A pin that reappears (pins_up=1 where standing=0) is ignored and never counted twice.
- Frame advance after each roll:
  - Frames 1-9, ball 1: count 10 -> strike, rack, frame+1, ball 1. Otherwise -> ball 2.
  - Frames 1-9, ball 2: rack, frame+1, ball 1.
  - Frame 10, ball 1: strike -> rack. Always -> ball 2.
  - Frame 10, ball 2: after a ball-1 strike, rack if ball 2 is a strike, then -> ball 3. No ball-1 strike and ball1+ball2=10 -> rack, ball 3. Otherwise game end.
  - Frame 10, ball 3: always game end.
  - Maximum 21 rolls per game.
- Rack: rack_reset is high on the first RACK cycle. standing <= 10'h3FF. RACK lasts RACK_CYCLES cycles, then IDLE.
- Game end: SCORE with calculate_score high for SCORE_CYCLES consecutive cycles, starting the cycle after roll falls. Then DONE, game_over=1. No rack_reset is issued on the final ball.
- DONE: ball_done is ignored, and no ball_ignored pulse is raised here. new_game -> game_start pulse, frame 1, ball 1, standing 3FF, rack_reset pulse, then RACK.
- ball_done in SETTLE, SAMPLE, RACK or SCORE: ignored, with a ball_ignored pulse the next cycle. State and counters are unaffected.
- new_game outside DONE: ignored.
- Simultaneous ball_done and new_game in DONE: new_game wins.

Test Plan:
- Reset -> all outputs 0, frame=1, ball_in_frame=1, no pulses for 100 cycles without ball_done.
- ball_done with pins_up=10'b0000000011 -> one roll, pin_count=8, exactly SETTLE_CYCLES+1 edges after ball_done; ball_in_frame=2, no rack_reset.
- Continuing, pins_up=10'b0000000001 -> pin_count=1 (not cumulative 9); rack_reset pulse; frame=2, ball_in_frame=1; RACK lasts 32 cycles.
- 12 balls with pins_up=0 -> 12 rolls of pin_count=10, 11 rack_resets, calculate_score high 10 cycles, game_over=1. A downstream scorer reset by game_start reads 300.
- Two frame-10 cases:
  - 20 balls with pins_up=3FF -> 20 rolls of 0, game end after ball 20.
  - 18 zeros, then 5 and 5 -> rack, ball 3 accepted, game end after 21 rolls.
- Three disturbance cases:
  - ball_done during SETTLE -> ball_ignored pulse, single roll.
  - Reset asserted mid-SETTLE -> immediate clear, no roll.
  - new_game in DONE -> game_start and rack_reset pulses, frame=1.
